// File: rtl/tiny_alu_arbiter.sv
// Round-robin arbiter sharing one tiny_alu among NUM_REQ requesters.
// One operation in flight; no-ops complete locally, a watchdog ends ALU hangs.
module tiny_alu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int OP_W           = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [2*DATA_W-1:0]       rsp_result_o,
  output logic                      rsp_error_o,
  output logic                      alu_start_o,
  output logic [OP_W-1:0]           alu_op_o,
  output logic [DATA_W-1:0]         alu_a_o,
  output logic [DATA_W-1:0]         alu_b_o,
  input  logic                      alu_done_i,
  input  logic [2*DATA_W-1:0]       alu_result_i
);

  // state | meaning
  // IDLE  | arbitrating, ready offered to the granted requester
  // BUSY  | start held high, waiting for done or watchdog
  // RESP  | one-cycle response strobe to the owner
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ID_W:0]    NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [OP_W-1:0]  OP_NOP    = '0;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, owner, grant_id;
  logic                grant_vld;
  logic [ID_W:0]       probe;
  logic [OP_W-1:0]     op_q, sel_op;
  logic [DATA_W-1:0]   a_q, b_q, sel_a, sel_b;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] result_q;
  logic                error_q;
  logic                timeout;
  logic                transfer;

  // Descending scan so the requester closest to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    probe     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      probe = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (probe >= NUM_REQ_X) probe = probe - NUM_REQ_X;
      if (req_valid_i[probe[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = probe[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_op = req_op_i[i*OP_W +: OP_W];
        sel_a  = req_a_i[i*DATA_W +: DATA_W];
        sel_b  = req_b_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign transfer = (state == IDLE) && grant_vld;
  assign timeout  = (cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_vld) state_nxt = (sel_op == OP_NOP) ? RESP : BUSY;
      BUSY: if (alu_done_i || timeout) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    rsp_result_o = '0;
    rsp_error_o  = 1'b0;
    alu_start_o  = 1'b0;
    alu_op_o     = '0;
    alu_a_o      = '0;
    alu_b_o      = '0;
    case (state)
      IDLE: if (grant_vld) req_ready_o[grant_id] = 1'b1;
      BUSY: begin
        alu_start_o = 1'b1;
        alu_op_o    = op_q;
        alu_a_o     = a_q;
        alu_b_o     = b_q;
      end
      RESP: begin
        rsp_valid_o[owner] = 1'b1;
        rsp_result_o       = result_q;
        rsp_error_o        = error_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr   <= '0;
      owner    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else if (transfer) begin
      owner    <= grant_id;
      op_q     <= sel_op;
      a_q      <= sel_a;
      b_q      <= sel_b;
      rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      cnt      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      // done takes precedence over a coincident watchdog expiry
      if (alu_done_i) begin
        result_q <= alu_result_i;
        error_q  <= 1'b0;
      end else if (timeout) begin
        result_q <= '0;
        error_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tiny_alu_arbiter.sv
// Bench for tiny_alu_arbiter: behavioural ALU with programmable latency,
// reference round-robin pointer and result arithmetic kept in the bench.
module tb_tiny_alu_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int OW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*OW-1:0] req_op;
  logic [2*DW-1:0] rsp_result, alu_result;
  logic            rsp_error, alu_start, alu_done;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_a, alu_b;

  int n_assert = 0;
  int n_fail = 0;
  int lat = 1;
  bit hang = 1'b0;
  int mcnt;
  int ref_ptr = 0;
  logic [OW-1:0] rop[N];
  logic [DW-1:0] ra[N], rb[N];

  tiny_alu_arbiter dut (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .rsp_valid_o(rsp_valid), .rsp_result_o(rsp_result), .rsp_error_o(rsp_error),
    .alu_start_o(alu_start), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_done_i(alu_done), .alu_result_i(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd1: return {8'h00, a} + {8'h00, b};
      3'd2: return {8'h00, a & b};
      3'd3: return {8'h00, a ^ b};
      3'd4: return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  // ALU model: done in the lat-th cycle of start being high, unless hung.
  always @(posedge clk or posedge rst)
    if (rst) mcnt <= 0;
    else if (alu_start) mcnt <= mcnt + 1;
    else mcnt <= 0;
  assign alu_done = !hang && alu_start && (mcnt == lat - 1);
  assign alu_result = alu_done ? ref_result(alu_op, alu_a, alu_b) : 16'h0000;

  function automatic int ref_grant(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) if (mask[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    rop[i] = op; ra[i] = a; rb[i] = b;
    req_op[i*OW +: OW] = op;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  // Drives one offer and observes the resulting operation; no judging here.
  task automatic run_txn(input logic [N-1:0] mask, output logic [N-1:0] rdy, output int starts,
                         output int rsp_cyc, output logic [N-1:0] rsp_m, output logic [15:0] res,
                         output logic err, output logic start_at_rsp, output logic [OW-1:0] s_op,
                         output logic [DW-1:0] s_a, output logic [DW-1:0] s_b, output bit stable);
    @(negedge clk);
    req_valid = mask;
    #1 rdy = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    starts = 0; rsp_cyc = -1; rsp_m = '0; res = '0; err = 1'b0; start_at_rsp = 1'b1;
    s_op = '0; s_a = '0; s_b = '0; stable = 1'b1;
    for (int c = 1; c <= 60 && rsp_cyc < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (alu_start) begin
        if (starts == 0) begin s_op = alu_op; s_a = alu_a; s_b = alu_b; end
        else if (s_op !== alu_op || s_a !== alu_a || s_b !== alu_b) stable = 1'b0;
        starts++;
      end
      if (rsp_valid !== '0) begin
        rsp_cyc = c; rsp_m = rsp_valid; res = rsp_result; err = rsp_error; start_at_rsp = alu_start;
      end
    end
  endtask

  logic [N-1:0] t_rdy, t_rsp, e_m;
  int t_starts, t_cyc;
  logic [15:0] t_res;
  logic t_err, t_sar;
  logic [OW-1:0] t_op;
  logic [DW-1:0] t_a, t_b;
  bit t_stab;

  task automatic test_reset;
    rst = 1'b1;
    #2;
    n_assert++;
    if ({alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_error, req_ready} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got start=%b rsp_valid=%b ready=%b, required all zero", alu_start, rsp_valid, req_ready);
    end
    @(negedge clk); rst = 1'b0; ref_ptr = 0;
  endtask

  task automatic test_single_add;
    set_req(0, 3'd1, 8'hFF, 8'h01); lat = 1; hang = 1'b0;
    run_txn(4'b0001, t_rdy, t_starts, t_cyc, t_rsp, t_res, t_err, t_sar, t_op, t_a, t_b, t_stab);
    ref_ptr = 1;
    n_assert++; if (t_rdy !== 4'b0001) begin n_fail++; $display("FAIL add_ready: got %b required 0001", t_rdy); end
    n_assert++; if (t_starts !== 1) begin n_fail++; $display("FAIL add_start_cycles: got %0d required 1", t_starts); end
    n_assert++; if (t_rsp !== 4'b0001) begin n_fail++; $display("FAIL add_rsp_valid: got %b required 0001", t_rsp); end
    n_assert++; if (t_res !== 16'h0100 || t_err !== 1'b0) begin n_fail++; $display("FAIL add_result: got %h err %b required 0100 err 0", t_res, t_err); end
    n_assert++; if (t_cyc !== 2 || t_sar !== 1'b0) begin n_fail++; $display("FAIL add_latency: got rsp cycle %0d start %b required 2 start 0", t_cyc, t_sar); end
    n_assert++; if (t_op !== 3'd1 || t_a !== 8'hFF || t_b !== 8'h01) begin n_fail++; $display("FAIL add_alu_operands: got op %h a %h b %h required 1 ff 01", t_op, t_a, t_b); end
  endtask

  task automatic test_mul;
    set_req(2, 3'd4, 8'hFF, 8'hFF); lat = 3;
    run_txn(4'b0100, t_rdy, t_starts, t_cyc, t_rsp, t_res, t_err, t_sar, t_op, t_a, t_b, t_stab);
    ref_ptr = 3;
    n_assert++; if (t_starts !== 3 || !t_stab) begin n_fail++; $display("FAIL mul_start_cycles: got %0d stable %b required 3 stable 1", t_starts, t_stab); end
    n_assert++; if (t_rsp !== 4'b0100) begin n_fail++; $display("FAIL mul_rsp_valid: got %b required 0100", t_rsp); end
    n_assert++; if (t_res !== 16'hFE01 || t_err !== 1'b0) begin n_fail++; $display("FAIL mul_result: got %h err %b required fe01 err 0", t_res, t_err); end
    n_assert++; if (t_cyc !== 4) begin n_fail++; $display("FAIL mul_latency: got %0d required 4", t_cyc); end
  endtask

  task automatic test_noop;
    set_req(1, 3'd0, 8'h55, 8'h77);
    run_txn(4'b0010, t_rdy, t_starts, t_cyc, t_rsp, t_res, t_err, t_sar, t_op, t_a, t_b, t_stab);
    ref_ptr = 2;
    n_assert++; if (t_rdy !== 4'b0010) begin n_fail++; $display("FAIL noop_ready: got %b required 0010", t_rdy); end
    n_assert++; if (t_starts !== 0) begin n_fail++; $display("FAIL noop_start: got %0d start cycles required 0", t_starts); end
    n_assert++; if (t_cyc !== 1 || t_rsp !== 4'b0010) begin n_fail++; $display("FAIL noop_rsp: got cycle %0d valid %b required 1 0010", t_cyc, t_rsp); end
    n_assert++; if (t_res !== 16'h0000 || t_err !== 1'b0) begin n_fail++; $display("FAIL noop_result: got %h err %b required 0 err 0", t_res, t_err); end
  endtask

  task automatic test_timeout;
    set_req(3, 3'd5, 8'h03, 8'h04); hang = 1'b1;
    run_txn(4'b1000, t_rdy, t_starts, t_cyc, t_rsp, t_res, t_err, t_sar, t_op, t_a, t_b, t_stab);
    ref_ptr = 0;
    n_assert++; if (t_starts !== 16 || t_cyc !== 17) begin n_fail++; $display("FAIL timeout_span: got start %0d rsp cycle %0d required 16 17", t_starts, t_cyc); end
    n_assert++; if (t_rsp !== 4'b1000 || t_err !== 1'b1 || t_res !== 16'h0000) begin n_fail++; $display("FAIL timeout_rsp: got valid %b err %b res %h required 1000 1 0", t_rsp, t_err, t_res); end
    hang = 1'b0; lat = 2;
    set_req(0, 3'd1, 8'h10, 8'h20);
    run_txn(4'b0001, t_rdy, t_starts, t_cyc, t_rsp, t_res, t_err, t_sar, t_op, t_a, t_b, t_stab);
    ref_ptr = 1;
    n_assert++; if (t_rsp !== 4'b0001 || t_res !== 16'h0030 || t_err !== 1'b0 || t_starts !== 2) begin
      n_fail++; $display("FAIL after_timeout: got valid %b res %h err %b start %0d required 0001 0030 0 2", t_rsp, t_res, t_err, t_starts); end
  endtask

  task automatic test_round_robin;
    int exp_g[7];
    logic [N-1:0] masks[7];
    exp_g = '{0, 1, 2, 3, 0, 1, 3};
    masks = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0010, 4'b1001};
    @(negedge clk); rst = 1'b1; #1 rst = 1'b0; ref_ptr = 0;
    lat = 1;
    for (int i = 0; i < N; i++) set_req(i, 3'd1, 8'(i * 16), 8'(i + 1));
    for (int k = 0; k < 7; k++) begin
      run_txn(masks[k], t_rdy, t_starts, t_cyc, t_rsp, t_res, t_err, t_sar, t_op, t_a, t_b, t_stab);
      e_m = '0; e_m[exp_g[k]] = 1'b1;
      ref_ptr = (exp_g[k] + 1) % N;
      n_assert++; if (t_rdy !== e_m || t_rsp !== e_m) begin n_fail++; $display("FAIL rr_grant_%0d: got ready %b rsp %b required %b", k, t_rdy, t_rsp, e_m); end
      n_assert++; if (t_res !== ref_result(3'd1, ra[exp_g[k]], rb[exp_g[k]])) begin n_fail++; $display("FAIL rr_result_%0d: got %h required %h", k, t_res, ref_result(3'd1, ra[exp_g[k]], rb[exp_g[k]])); end
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [N-1:0] seen;
    set_req(2, 3'd4, 8'h12, 8'h34); hang = 1'b1;
    @(negedge clk); req_valid = 4'b0100;
    @(posedge clk);
    @(negedge clk); req_valid = '0;
    n_assert++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL midreset_busy: got start %b required 1", alu_start); end
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if ({alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_error, req_ready} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got start=%b a=%h rsp_valid=%b, required all zero", alu_start, alu_a, rsp_valid);
    end
    seen = '0;
    repeat (3) begin @(negedge clk); seen |= rsp_valid; end
    rst = 1'b0; ref_ptr = 0; hang = 1'b0; lat = 1;
    repeat (3) begin @(negedge clk); seen |= rsp_valid; end
    n_assert++; if (seen !== '0) begin n_fail++; $display("FAIL midreset_no_rsp: got %b required 0000", seen); end
    for (int i = 0; i < N; i++) set_req(i, 3'd3, 8'(i + 5), 8'hA0);
    run_txn(4'b1111, t_rdy, t_starts, t_cyc, t_rsp, t_res, t_err, t_sar, t_op, t_a, t_b, t_stab);
    ref_ptr = 1;
    n_assert++; if (t_rdy !== 4'b0001 || t_rsp !== 4'b0001) begin n_fail++; $display("FAIL midreset_ptr: got ready %b rsp %b required 0001", t_rdy, t_rsp); end
  endtask

  task automatic test_random;
    logic [N-1:0] mask;
    int g, e_starts, e_cyc;
    logic [15:0] e_res;
    for (int it = 0; it < 30; it++) begin
      mask = 4'($urandom_range(1, 15));
      lat = int'($urandom_range(1, 5));
      for (int i = 0; i < N; i++) set_req(i, 3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom));
      g = ref_grant(mask);
      e_m = '0; e_m[g] = 1'b1;
      e_res = ref_result(rop[g], ra[g], rb[g]);
      e_starts = (rop[g] == 3'd0) ? 0 : lat;
      e_cyc = e_starts + 1;
      run_txn(mask, t_rdy, t_starts, t_cyc, t_rsp, t_res, t_err, t_sar, t_op, t_a, t_b, t_stab);
      ref_ptr = (g + 1) % N;
      n_assert++; if (t_rdy !== e_m || t_rsp !== e_m) begin n_fail++; $display("FAIL rand_grant_%0d: got ready %b rsp %b required %b", it, t_rdy, t_rsp, e_m); end
      n_assert++; if (t_res !== e_res || t_err !== 1'b0) begin n_fail++; $display("FAIL rand_result_%0d: got %h err %b required %h err 0", it, t_res, t_err, e_res); end
      n_assert++; if (t_starts !== e_starts || t_cyc !== e_cyc) begin n_fail++; $display("FAIL rand_timing_%0d: got start %0d rsp %0d required %0d %0d", it, t_starts, t_cyc, e_starts, e_cyc); end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    test_reset();
    test_single_add();
    test_mul();
    test_noop();
    test_timeout();
    test_round_robin();
    test_reset_mid_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
